// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control FSM and the multiply/divide unit.
// The control FSM drives the master side and the unit drives the slave side.
// start is a request that the unit samples only while busy is low. Once busy
// rises, the operands are captured and start is ignored until done pulses.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide unit that owns the HI/LO registers.
// Multiply uses shift-add with the multiplier LSB first. Divide uses restoring
// division with quotient bits MSB first. Both run on magnitudes and fix up the
// signs in FIN. One iteration runs per cycle, and each operation takes WIDTH
// iterations.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus,
  output logic [1:0]     dbgState
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic             isDiv;
  logic             negRes;   // product or quotient must be negated
  logic             negRem;   // remainder must be negated (dividend was negative)
  logic             divZero;
  logic [WIDTH-1:0] opnd;     // multiplicand magnitude, or divisor magnitude
  logic [WIDTH:0]   accHi;    // product high half, or partial remainder
  logic [WIDTH-1:0] accLo;    // multiplier/product low half, or dividend/quotient
  logic [CW-1:0]    count;
  logic             doneReg;
  logic             divZeroReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  // Operand decode for the request currently presented on the bus.
  logic             signedOp, aNeg, bNeg, reqDiv;
  logic [WIDTH-1:0] aAbs, bAbs;
  assign signedOp = ~bus.op[0];
  assign reqDiv   = bus.op[1];
  assign aNeg     = signedOp & bus.a[WIDTH-1];
  assign bNeg     = signedOp & bus.b[WIDTH-1];
  assign aAbs     = aNeg ? -bus.a : bus.a;
  assign bAbs     = bNeg ? -bus.b : bus.b;

  // Datapath for a single iteration step.
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] product, prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;
  assign mulSum   = accHi + (accLo[0] ? {1'b0, opnd} : '0);
  assign divShift = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opnd};
  assign product  = {accHi[WIDTH-1:0], accLo};
  assign prodFix  = negRes ? -product : product;
  assign quotFix  = negRes ? -accLo : accLo;
  assign remFix   = negRem ? -accHi[WIDTH-1:0] : accHi[WIDTH-1:0];

  // Control FSM and datapath registers. done and div_zero are one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      isDiv      <= 1'b0;
      negRes     <= 1'b0;
      negRem     <= 1'b0;
      divZero    <= 1'b0;
      opnd       <= '0;
      accHi      <= '0;
      accLo      <= '0;
      count      <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            isDiv   <= reqDiv;
            negRes  <= aNeg ^ bNeg;
            negRem  <= aNeg;
            opnd    <= reqDiv ? bAbs : aAbs;
            accHi   <= '0;
            accLo   <= reqDiv ? aAbs : bAbs;
            count   <= '0;
            // A zero divisor skips the iterations entirely.
            divZero <= reqDiv && (bus.b == '0);
            state   <= (reqDiv && (bus.b == '0)) ? FIN : RUN;
          end
        end
        RUN: begin
          if (isDiv) begin
            // Restoring step: keep the subtraction only if it did not borrow.
            if (!divDiff[WIDTH]) begin
              accHi <= divDiff;
              accLo <= {accLo[WIDTH-2:0], 1'b1};
            end else begin
              accHi <= divShift;
              accLo <= {accLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            accHi <= {1'b0, mulSum[WIDTH:1]};
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == LAST) state <= FIN;
        end
        FIN: begin
          doneReg    <= 1'b1;
          divZeroReg <= divZero;
          divZero    <= 1'b0;
          if (!divZero) begin
            hiReg <= isDiv ? remFix  : prodFix[2*WIDTH-1:WIDTH];
            loReg <= isDiv ? quotFix : prodFix[WIDTH-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = doneReg;
  assign bus.div_zero = divZeroReg;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;
  assign dbgState     = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8. Drivers push
// {div_zero, hi, lo} and the expected done cycle; monitors pop them on done.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus32();
  mult_div_unit_if #(.WIDTH(8))  bus8();
  logic [1:0] dbg32, dbg8;

  mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32), .dbgState(dbg32));
  mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8),  .dbgState(dbg8));

  int nVec = 0;
  int nMis = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [64:0] exp32_q[$];
  int          expCyc32_q[$];
  logic [16:0] exp8_q[$];
  int          expCyc8_q[$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit unit.
  logic prevDone32 = 1'b0;
  always @(negedge clk) begin : mon32
    logic [64:0] e;
    int c;
    if (prevDone32) check("done32_one_cycle", {64'd0, bus32.done}, 65'd0);
    if (bus32.done === 1'b1) begin
      check("busy32_with_done", {64'd0, bus32.busy}, 65'd0);
      if (exp32_q.size() == 0) begin
        check("unexpected_done32", 65'd1, 65'd0);
      end else begin
        e = exp32_q.pop_front();
        c = expCyc32_q.pop_front();
        check("result32", {bus32.div_zero, bus32.hi, bus32.lo}, e);
        check("latency32", 65'(cyc), 65'(c));
      end
    end
    prevDone32 = bus32.done;
  end

  // Monitor for the 8-bit unit.
  logic prevDone8 = 1'b0;
  always @(negedge clk) begin : mon8
    logic [16:0] e;
    int c;
    if (prevDone8) check("done8_one_cycle", {64'd0, bus8.done}, 65'd0);
    if (bus8.done === 1'b1) begin
      check("busy8_with_done", {64'd0, bus8.busy}, 65'd0);
      if (exp8_q.size() == 0) begin
        check("unexpected_done8", 65'd1, 65'd0);
      end else begin
        e = exp8_q.pop_front();
        c = expCyc8_q.pop_front();
        check("result8", {48'd0, bus8.div_zero, bus8.hi, bus8.lo}, {48'd0, e});
        check("latency8", 65'(cyc), 65'(c));
      end
    end
    prevDone8 = bus8.done;
  end

  // Issue one 32-bit op; returns just after the start edge (edge 0).
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [64:0] exp, input bit dz);
    @(posedge clk); #1;
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    exp32_q.push_back(exp);
    expCyc32_q.push_back(dz ? cyc + 2 : cyc + 34);
    @(posedge clk); #1;
    bus32.start = 1'b0;
    bus32.a     = ~a;
    bus32.b     = ~b;
    check("busy32_after_start", {64'd0, bus32.busy}, 65'd1);
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [16:0] exp);
    @(posedge clk); #1;
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    exp8_q.push_back(exp);
    expCyc8_q.push_back(cyc + 10);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a     = ~a;
    bus8.b     = ~b;
    check("busy8_after_start", {64'd0, bus8.busy}, 65'd1);
  endtask

  task automatic wait32(input int extra);
    for (int i = 0; i < 100; i++) begin
      if (exp32_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp32_q.size() != 0) begin
      check("timeout32", 65'(exp32_q.size()), 65'd0);
      exp32_q.delete();
      expCyc32_q.delete();
    end
    repeat (extra) @(posedge clk);
  endtask

  task automatic wait8(input int extra);
    for (int i = 0; i < 100; i++) begin
      if (exp8_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp8_q.size() != 0) begin
      check("timeout8", 65'(exp8_q.size()), 65'd0);
      exp8_q.delete();
      expCyc8_q.delete();
    end
    repeat (extra) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.op  = 2'b00; bus8.a  = '0; bus8.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset32_outputs", {bus32.busy, bus32.done, bus32.div_zero, 30'd0, dbg32, bus32.hi[31:0]}, 65'd0);
    check("reset32_lo", {33'd0, bus32.lo}, 65'd0);
    check("reset8_outputs", {bus8.busy, bus8.done, bus8.div_zero, dbg8, bus8.hi, bus8.lo}, 65'd0);
    @(negedge clk);
    reset = 1'b1;

    // 32-bit directed vectors: {div_zero, hi, lo}
    issue32(2'b00, 32'hFFFFFFFD, 32'd7,        {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}, 1'b0); wait32(2);
    issue32(2'b10, 32'hFFFFFFF9, 32'd2,        {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0); wait32(2);
    issue32(2'b11, 32'hFFFFFFFF, 32'h10,       {1'b0, 32'h0000000F, 32'h0FFFFFFF}, 1'b0); wait32(2);
    issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}, 1'b0); wait32(2);
    issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001}, 1'b0); wait32(2);
    issue32(2'b00, 32'h80000000, 32'h80000000, {1'b0, 32'h40000000, 32'h00000000}, 1'b0); wait32(2);
    issue32(2'b11, 32'd100,      32'd7,        {1'b0, 32'd2,        32'd14},       1'b0); wait32(2);
    issue32(2'b01, 32'd5,        32'd3,        {1'b0, 32'd0,        32'd15},       1'b0); wait32(2);
    issue32(2'b10, 32'h1234,     32'd0,        {1'b1, 32'd0,        32'd15},       1'b1); wait32(2);
    issue32(2'b10, 32'd7,        32'hFFFFFFFE, {1'b0, 32'd1,        32'hFFFFFFFD}, 1'b0); wait32(2);

    // 8-bit MULTU with a second start at edge 4 that must be ignored.
    issue8(2'b01, 8'hFF, 8'hFF, {1'b0, 8'hFE, 8'h01});
    repeat (3) @(posedge clk);
    #1;
    bus8.start = 1'b1; bus8.op = 2'b00; bus8.a = 8'd1; bus8.b = 8'd1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait8(14);

    // Reset in the middle of a 32-bit MULT discards it and clears HI/LO.
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.op = 2'b00; bus32.a = 32'hFFFFFFFD; bus32.b = 32'd7;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrun_reset_ctrl", {62'd0, bus32.busy, bus32.done, bus32.div_zero}, 65'd0);
    check("midrun_reset_hilo", {1'b0, bus32.hi, bus32.lo}, 65'd0);
    check("midrun_reset_state", {63'd0, dbg32}, 65'd0);
    @(negedge clk);
    reset = 1'b1;
    issue32(2'b01, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, 1'b0);
    wait32(3);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Iterative integer multiply/divide unit for the multi-cycle MIPS datapath.
- Parametrised by operand width; supports signed and unsigned multiply and divide.
- Runs a start/busy/done handshake with the control FSM and owns the HI/LO result registers.
- Replaces the separate fixed-width mult and div blocks; the control unit stalls on `busy` and moves HI/LO into the register file after `done`.

## Interface
- `WIDTH`, default 32: operand width in bits; HI and LO are each `WIDTH` bits; minimum 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`  in  `WIDTH`  multiplicand / dividend; sampled with `start`.
- `b`  in  `WIDTH`  multiplier / divisor; sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE; combinational from state.
- `done`  out  1  registered, one-cycle pulse; HI/LO are valid in the same cycle.
- `div_zero`  out  1  registered, one-cycle pulse coincident with `done`, for DIV/DIVU with `b`=0.
- `hi`  out  `WIDTH`  HI register.
- `lo`  out  `WIDTH`  LO register.

## Operation
- FSM states: IDLE, RUN, FIN.
- **IDLE, `start`=1:**
  - Latch op, sign flags, |a| and |b| (magnitudes for signed ops, raw values for unsigned).
  - Clear the iteration counter and go to RUN.
  - Exception: DIV/DIVU with `b`=0 goes straight to FIN with the zero flag set.
- **RUN:** one iteration per cycle, exactly `WIDTH` iterations, then FIN.
  - Multiply: shift-add on a 2·`WIDTH` accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first; remainder register is `WIDTH`+1 bits.
- **FIN:** apply sign correction, then return to IDLE on the next edge. On that edge:
  - Assert `done` for one cycle.
  - Load HI/LO, except on divide-by-zero.
- Multiply result: the 2·`WIDTH` product, negated if MULT and the operand signs differ. `hi` = upper half, `lo` = lower half.
- Divide result: `lo` = quotient, `hi` = remainder.
  - Signed quotient truncates toward zero (negated if signs differ).
  - Signed remainder takes the sign of the dividend.
- Most-negative ÷ −1 (DIV): `lo` = most-negative value (wraps), `hi` = 0; `div_zero` stays low.
- Divide-by-zero:
  - `done` and `div_zero` pulse together.
  - `hi`/`lo` retain their previous values.
  - No RUN cycles are spent.
- HI/LO hold their value until the next completion or reset; no other path writes them.
- `start` while `busy` is ignored. It is not queued, and the in-flight operands and op are unaffected.
- Operands may change after the start edge without effect.

## Timing
- The start edge is edge 0.
- Normal ops:
  - RUN occupies edges 1..`WIDTH`.
  - FIN→IDLE at edge `WIDTH`+1; `done` high, new HI/LO visible, and `busy` low, all in the cycle after that edge.
  - Latency from start edge to `done` is `WIDTH`+1 edges (33 for `WIDTH`=32).
- Divide-by-zero: FIN→IDLE at edge 1; `done`/`div_zero` are visible after edge 1.
- `busy` is high from after edge 0 until `done` rises; `busy` and `done` are never both high.
- A new `start` in the same cycle that `done` is high is accepted, since the FSM is in IDLE; back-to-back throughput is one op per `WIDTH`+2 cycles.
- Reset (asynchronous, any state, including mid-RUN):
  - State → IDLE; `busy`, `done`, `div_zero` → 0; `hi`, `lo`, counter and internal registers → 0.
  - The partial result is discarded.
  - The first start edge after release behaves exactly as edge 0.

## Test plan
- MULT, `WIDTH`=32, a=0xFFFFFFFD (−3), b=7 → after edge 33: `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy`=0; `done` low the following cycle.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=0x10 → `lo`=0x0FFFFFFF, `hi`=0xF.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- Preload HI/LO via MULTU 5×3 (`hi`=0, `lo`=15), then DIV b=0:
  - After edge 1, `done`=1 and `div_zero`=1.
  - `hi`/`lo` still 0/15.
- `WIDTH`=8, MULTU 0xFF×0xFF:
  - `hi`=0xFE, `lo`=0x01, `done` after edge 9.
  - A second `start` pulsed at edge 4 is ignored (result unchanged, no extra `done`).
- Reset low at edge 10 of a 32-bit MULT:
  - `busy`/`done`/`hi`/`lo` are 0 immediately.
  - After release, MULTU 2×3 yields `lo`=6 exactly 33 edges after its start.
